// File: rtl/ascii_display_scanner.sv
// Time-multiplexed scanner feeding one ASCII decoder: holds a DIGITS-entry
// character buffer, walks it one slot at a time and drives digit select plus ABI PWM.
module ascii_display_scanner #(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int STEP         = 66,
  localparam int AW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              CLR,
  input  logic [3:0]        BRT,
  input  logic              WE,
  input  logic [AW-1:0]     WA,
  input  logic [6:0]        WD,
  output logic              WRDY,
  output logic              D0,
  output logic              D1,
  output logic              D2,
  output logic              D3,
  output logic              D4,
  output logic              D5,
  output logic              D6,
  output logic              ABI,
  output logic [DIGITS-1:0] DIG,
  output logic              FRM
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   k, k_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            clr_wr;
  logic            slot_start;
  logic            lit_nxt;
  logic [31:0]     cnt_ext;
  logic [6:0]      chr;
  logic [6:0]      buffer [DIGITS];

  assign WRDY = (state == S_IDLE || state == S_SCAN) && !CLR;
  assign {D6, D5, D4, D3, D2, D1, D0} = chr;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    clr_wr    = 1'b0;
    if (CLR) begin
      state_nxt = S_CLEAR;
      k_nxt     = '0;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_wr = 1'b1;
          if (k == AW'(DIGITS - 1)) begin
            state_nxt = EN ? S_SCAN : S_IDLE;
            k_nxt     = '0;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
        S_IDLE: begin
          if (EN) state_nxt = S_SCAN;
        end
        S_SCAN: begin
          if (!EN) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
          end else if (cnt == CW'(PRESCALE - 1)) begin
            cnt_nxt = '0;
            idx_nxt = (idx == AW'(DIGITS - 1)) ? '0 : idx + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = S_CLEAR;
      endcase
    end
  end

  // Outputs are registered from next-state values so DIG/ABI/FRM switch together.
  assign slot_start = (state_nxt == S_SCAN) && (cnt_nxt == '0);
  assign cnt_ext    = 32'(cnt_nxt);
  assign lit_nxt    = (state_nxt == S_SCAN) && (cnt_ext >= 32'(BLANK_CYCLES)) &&
                      (cnt_ext < 32'(BLANK_CYCLES) + 32'(BRT) * 32'(STEP));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_CLEAR;
      k     <= '0;
      idx   <= '0;
      cnt   <= '0;
      DIG   <= '0;
      chr   <= '0;
      ABI   <= 1'b0;
      FRM   <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      DIG   <= (state_nxt == S_SCAN) ? (DIGITS'(1) << idx_nxt) : '0;
      if (slot_start) chr <= buffer[idx_nxt];
      ABI   <= lit_nxt;
      FRM   <= slot_start && (idx_nxt == '0);
    end
  end

  // Buffer has no reset; CLEAR refills it with spaces before any scan.
  always_ff @(posedge CLK) begin
    if (clr_wr)
      buffer[k] <= 7'h20;
    else if (WE && WRDY && int'(WA) < DIGITS)
      buffer[WA] <= WD;
  end
endmodule

// File: tb/tb_ascii_display_scanner.sv
// Randomized bench for ascii_display_scanner against a time-since-scan-start model.
module tb_ascii_display_scanner;
  localparam int DIGITS = 4, PRESCALE = 20, BLANK = 2, STEP = 1;

  logic       CLK = 1'b0, RST = 1'b1, EN = 1'b0, CLR = 1'b0, WE = 1'b0;
  logic [3:0] BRT = 4'd0;
  logic [1:0] WA = 2'd0;
  logic [6:0] WD = 7'd0;
  logic       WRDY, D0, D1, D2, D3, D4, D5, D6, ABI, FRM;
  logic [3:0] DIG;

  logic       en5 = 1'b0, we5 = 1'b0, clr5 = 1'b0;
  logic [2:0] wa5 = 3'd0;
  logic [6:0] wd5 = 7'd0;
  logic       wrdy5, q0, q1, q2, q3, q4, q5, q6, abi5, frm5;
  logic [4:0] dig5;

  ascii_display_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK), .STEP(STEP)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .BRT(BRT), .WE(WE), .WA(WA), .WD(WD),
    .WRDY(WRDY), .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6),
    .ABI(ABI), .DIG(DIG), .FRM(FRM));

  // Five positions so the 3-bit address can reach past the buffer.
  ascii_display_scanner #(.DIGITS(5), .PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK), .STEP(STEP)) u_dut5 (
    .CLK(CLK), .RST(RST), .EN(en5), .CLR(clr5), .BRT(BRT), .WE(we5), .WA(wa5), .WD(wd5),
    .WRDY(wrdy5), .D0(q0), .D1(q1), .D2(q2), .D3(q3), .D4(q4), .D5(q5), .D6(q6),
    .ABI(abi5), .DIG(dig5), .FRM(frm5));

  always #5 CLK = ~CLK;

  wire [6:0] dv  = {D6, D5, D4, D3, D2, D1, D0};
  wire [6:0] dv5 = {q6, q5, q4, q3, q2, q1, q0};

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=clearing, 1=idle, 2=scanning; m_t = cycles since scan start.
  int         m_mode, m_pos, m_t;
  logic [6:0] m_buf [DIGITS];
  logic [6:0] m_d;
  logic [3:0] m_dig;
  logic       m_abi, m_frm;

  function automatic int m_slot();
    return m_t % PRESCALE;
  endfunction

  function automatic int m_idx();
    return (m_t / PRESCALE) % DIGITS;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_t = 0;
    m_d = '0; m_dig = '0; m_abi = 1'b0; m_frm = 1'b0;
  endtask

  task automatic model_edge();
    logic [6:0] old_buf [DIGITS];
    int slot, idx;
    old_buf = m_buf;
    if (WE && m_mode != 0 && !CLR) m_buf[WA] = WD;
    if (CLR) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      m_buf[m_pos] = 7'h20;
      if (m_pos == DIGITS - 1) begin m_mode = EN ? 2 : 1; m_t = 0; end
      else m_pos++;
    end else if (m_mode == 1) begin
      if (EN) begin m_mode = 2; m_t = 0; end
    end else begin
      if (!EN) m_mode = 1;
      else m_t++;
    end
    if (m_mode == 2) begin
      slot  = m_slot();
      idx   = m_idx();
      m_dig = 4'(1 << idx);
      m_frm = (m_t % (DIGITS * PRESCALE)) == 0;
      m_abi = (slot >= BLANK) && (slot < BLANK + int'(BRT) * STEP);
      if (slot == 0) m_d = old_buf[idx];
    end else begin
      m_dig = '0; m_abi = 1'b0; m_frm = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("dig", 32'(DIG), 32'(m_dig));
    chk("d", 32'(dv), 32'(m_d));
    chk("abi", 32'(ABI), 32'(m_abi));
    chk("frm", 32'(FRM), 32'(m_frm));
    chk("wrdy", 32'(WRDY), 32'(m_mode != 0 && !CLR));
  endtask

  task automatic run(input int cycles, input int en_pct, input int clr_pct,
                     input int we_pct, input int brt);
    for (int i = 0; i < cycles; i++) begin
      step();
      EN  = ($urandom_range(99) < en_pct);
      CLR = ($urandom_range(99) < clr_pct);
      WE  = ($urandom_range(99) < we_pct);
      WA  = 2'($urandom_range(3));
      WD  = 7'($urandom);
      BRT = (brt < 0) ? 4'($urandom_range(15)) : 4'(brt);
    end
  endtask

  task automatic wait_pos(input string tag, input int idx, input int slot);
    int n = 0;
    while (!(m_mode == 2 && m_idx() == idx && m_slot() == slot) && n < 200) begin
      step(); n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_dig", 32'(DIG), 32'd0);
    chk("rst_d", 32'(dv), 32'd0);
    chk("rst_abi", 32'(ABI), 32'd0);
    chk("rst_frm", 32'(FRM), 32'd0);
    chk("rst_wrdy", 32'(WRDY), 32'd0);
    EN = 1'b1; BRT = 4'd15;
    @(posedge CLK); #1 RST = 1'b0;

    // Scan of a freshly cleared buffer.
    run(200, 100, 0, 0, 15);

    // "ABCD" then full-brightness scan.
    for (int i = 0; i < 4; i++) begin
      WE = 1'b1; WA = 2'(i); WD = 7'(8'h41 + i);
      step();
    end
    WE = 1'b0;
    run(200, 100, 0, 0, 15);

    // Brightness sweep.
    run(100, 100, 0, 0, 0);
    run(100, 100, 0, 0, 5);
    run(100, 100, 0, 0, 15);

    // Write to the digit on display, mid-slot.
    wait_pos("wait_mid", 1, 5);
    WE = 1'b1; WA = 2'd1; WD = 7'h5A;
    step();
    WE = 1'b0;
    run(100, 100, 0, 0, 15);

    // CLR and WE together: clear wins.
    CLR = 1'b1; WE = 1'b1; WA = 2'd1; WD = 7'h31;
    step();
    CLR = 1'b0; WE = 1'b0;
    run(120, 100, 0, 0, 15);

    // EN drop at slot_cnt 7 of digit 2, then restart.
    wait_pos("wait_en", 2, 7);
    EN = 1'b0;
    step();
    chk("endrop_dig", 32'(DIG), 32'd0);
    chk("endrop_abi", 32'(ABI), 32'd0);
    EN = 1'b1;
    step();
    chk("restart_dig", 32'(DIG), 32'd1);
    chk("restart_frm", 32'(FRM), 32'd1);

    // Random soak.
    run(2500, 97, 1, 25, -1);

    // Asynchronous reset mid-slot.
    EN = 1'b1; CLR = 1'b0; WE = 1'b0; BRT = 4'd15;
    wait_pos("wait_rst", 3, 4);
    #2 RST = 1'b1;
    #1;
    chk("arst_dig", 32'(DIG), 32'd0);
    chk("arst_abi", 32'(ABI), 32'd0);
    chk("arst_frm", 32'(FRM), 32'd0);
    chk("arst_d", 32'(dv), 32'd0);
    chk("arst_wrdy", 32'(WRDY), 32'd0);
    model_reset();
    @(posedge CLK); #1 RST = 1'b0;
    run(150, 100, 0, 30, -1);

    // Out-of-range writes on the five-position instance are discarded.
    for (int a = 7; a >= 0; a--) begin
      we5 = 1'b1; wa5 = 3'(a); wd5 = (a < 5) ? 7'(8'h61 + a) : 7'h7F;
      chk("wrdy5", 32'(wrdy5), 32'd1);
      @(posedge CLK); #1;
    end
    we5 = 1'b0; en5 = 1'b1;
    for (int c = 0; c < 5 * PRESCALE; c++) begin
      @(posedge CLK); #1;
      if (c % PRESCALE == 0) begin
        chk("d5", 32'(dv5), 32'(8'h61 + c / PRESCALE));
        chk("dig5", 32'(dig5), 32'(1 << (c / PRESCALE)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
